// File: rtl/interconnect_four_data_to_sfft_pkg.sv
// Shared constants and state encodings for the four-quarter to serial FFT merge stage.
package interconnect_four_data_to_sfft_pkg;

  localparam int DEFAULT_SIZE_BUFFER   = 4;
  localparam int DEFAULT_DATA_FFT_SIZE = 16;
  localparam int NFFT    = 1 << DEFAULT_SIZE_BUFFER;
  localparam int QUARTER = NFFT / 4;

  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    FILLING = 2'b01,
    FULL    = 2'b10
  } rx_state_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } out_state_t;

  // Index width inside one quarter; kept at least 1 bit so a depth-1 quarter still has a port.
  function automatic int quarter_idx_width(input int size_buffer);
    return (size_buffer > 2) ? size_buffer - 2 : 1;
  endfunction

endpackage

// File: rtl/interconnect_four_data_to_sfft_quarter_buffer_rx.sv
// One quarter-band receive buffer: I/Q storage, write counter and EMPTY/FILLING/FULL handshake FSM.
module quarter_buffer_rx
  import interconnect_four_data_to_sfft_pkg::*;
#(
  parameter int SIZE_BUFFER   = DEFAULT_SIZE_BUFFER,
  parameter int DATA_FFT_SIZE = DEFAULT_DATA_FFT_SIZE,
  localparam int IW    = quarter_idx_width(SIZE_BUFFER),
  localparam int DEPTH = (1 << SIZE_BUFFER) / 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     complete_data,
  input  logic [DATA_FFT_SIZE-1:0] data_i,
  input  logic [DATA_FFT_SIZE-1:0] data_q,
  output logic                     ready,
  output logic                     full,
  input  logic [IW-1:0]            rd_idx,
  output logic [DATA_FFT_SIZE-1:0] rd_data_i,
  output logic [DATA_FFT_SIZE-1:0] rd_data_q,
  input  logic                     release_quarter
);

  rx_state_t state;
  logic [IW-1:0] wr_cnt;
  logic [DATA_FFT_SIZE-1:0] mem_i [DEPTH];
  logic [DATA_FFT_SIZE-1:0] mem_q [DEPTH];
  logic wr_en;
  logic wr_last;

  // Ready is held low while reset is asserted even though the state already reads EMPTY.
  assign ready   = reset & (state != FULL);
  assign full    = (state == FULL);
  assign wr_en   = complete_data & ready;
  assign wr_last = (wr_cnt == IW'(DEPTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= EMPTY;
      wr_cnt <= '0;
    end else begin
      case (state)
        EMPTY, FILLING: begin
          if (wr_en) begin
            if (wr_last) begin
              state  <= FULL;
              wr_cnt <= '0;
            end else begin
              state  <= FILLING;
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end
        FULL: begin
          if (release_quarter) state <= EMPTY;
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Storage has no reset so it maps onto plain RAM; stale contents are never read before a refill.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_i[wr_cnt] <= data_i;
      mem_q[wr_cnt] <= data_q;
    end
  end

  assign rd_data_i = mem_i[rd_idx];
  assign rd_data_q = mem_q[rd_idx];

endmodule

// File: rtl/interconnect_four_data_to_sfft.sv
// Merges four quarter-band buffers into one serial NFFT-sample frame, quarter0 first.
module interconnect_four_data_to_sfft
  import interconnect_four_data_to_sfft_pkg::*;
#(
  parameter int SIZE_BUFFER   = DEFAULT_SIZE_BUFFER,
  parameter int DATA_FFT_SIZE = DEFAULT_DATA_FFT_SIZE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     complete_data0,
  input  logic                     complete_data1,
  input  logic                     complete_data2,
  input  logic                     complete_data3,
  input  logic [DATA_FFT_SIZE-1:0] data_in0_i,
  input  logic [DATA_FFT_SIZE-1:0] data_in1_i,
  input  logic [DATA_FFT_SIZE-1:0] data_in2_i,
  input  logic [DATA_FFT_SIZE-1:0] data_in3_i,
  input  logic [DATA_FFT_SIZE-1:0] data_in0_q,
  input  logic [DATA_FFT_SIZE-1:0] data_in1_q,
  input  logic [DATA_FFT_SIZE-1:0] data_in2_q,
  input  logic [DATA_FFT_SIZE-1:0] data_in3_q,
  output logic                     flag_ready_recive_data0,
  output logic                     flag_ready_recive_data1,
  output logic                     flag_ready_recive_data2,
  output logic                     flag_ready_recive_data3,
  input  logic                     flag_ready_fft,
  output logic                     fft_valid,
  output logic [DATA_FFT_SIZE-1:0] data_to_fft_i,
  output logic [DATA_FFT_SIZE-1:0] data_to_fft_q,
  output logic                     frame_start,
  output logic                     busy
);

  localparam int IW        = quarter_idx_width(SIZE_BUFFER);
  localparam int DEPTH     = (1 << SIZE_BUFFER) / 4;
  localparam int FRAME_LEN = 1 << SIZE_BUFFER;

  out_state_t out_state;
  logic [SIZE_BUFFER-1:0] rd_cnt;
  logic [1:0] rd_q;
  logic [IW-1:0] rd_idx;
  logic accept;
  logic q_last;

  logic [3:0] valid_vec;
  logic [3:0] ready_vec;
  logic [3:0] full_vec;
  logic [3:0] release_vec;
  logic [DATA_FFT_SIZE-1:0] din_i [4];
  logic [DATA_FFT_SIZE-1:0] din_q [4];
  logic [DATA_FFT_SIZE-1:0] rdat_i [4];
  logic [DATA_FFT_SIZE-1:0] rdat_q [4];

  assign valid_vec = {complete_data3, complete_data2, complete_data1, complete_data0};
  assign din_i[0] = data_in0_i;
  assign din_i[1] = data_in1_i;
  assign din_i[2] = data_in2_i;
  assign din_i[3] = data_in3_i;
  assign din_q[0] = data_in0_q;
  assign din_q[1] = data_in1_q;
  assign din_q[2] = data_in2_q;
  assign din_q[3] = data_in3_q;

  assign flag_ready_recive_data0 = ready_vec[0];
  assign flag_ready_recive_data1 = ready_vec[1];
  assign flag_ready_recive_data2 = ready_vec[2];
  assign flag_ready_recive_data3 = ready_vec[3];

  // The read counter is {quarter, index}; masking keeps the index at zero for depth-1 quarters.
  assign rd_q   = rd_cnt[SIZE_BUFFER-1 -: 2];
  assign rd_idx = IW'(rd_cnt) & IW'(DEPTH - 1);
  assign q_last = (rd_idx == IW'(DEPTH - 1));
  assign accept = fft_valid & flag_ready_fft;

  for (genvar k = 0; k < 4; k++) begin : g_quarter
    assign release_vec[k] = accept & q_last & (rd_q == 2'(k));

    quarter_buffer_rx #(
      .SIZE_BUFFER  (SIZE_BUFFER),
      .DATA_FFT_SIZE(DATA_FFT_SIZE)
    ) u_quarter (
      .clk            (clk),
      .reset          (reset),
      .complete_data  (valid_vec[k]),
      .data_i         (din_i[k]),
      .data_q         (din_q[k]),
      .ready          (ready_vec[k]),
      .full           (full_vec[k]),
      .rd_idx         (rd_idx),
      .rd_data_i      (rdat_i[k]),
      .rd_data_q      (rdat_q[k]),
      .release_quarter(release_vec[k])
    );
  end

  // Leaving SEND always passes through IDLE, which guarantees a gap cycle between frames.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_state <= IDLE;
      rd_cnt    <= '0;
    end else begin
      case (out_state)
        IDLE: begin
          if (&full_vec) out_state <= SEND;
        end
        SEND: begin
          if (flag_ready_fft) begin
            if (rd_cnt == SIZE_BUFFER'(FRAME_LEN - 1)) begin
              rd_cnt    <= '0;
              out_state <= IDLE;
            end else begin
              rd_cnt <= rd_cnt + 1'b1;
            end
          end
        end
        default: out_state <= IDLE;
      endcase
    end
  end

  assign fft_valid   = (out_state == SEND);
  assign busy        = (out_state != IDLE);
  assign frame_start = fft_valid & (rd_cnt == '0);

  always_comb begin
    data_to_fft_i = '0;
    data_to_fft_q = '0;
    if (fft_valid) begin
      data_to_fft_i = rdat_i[rd_q];
      data_to_fft_q = rdat_q[rd_q];
    end
  end

endmodule

// File: tb/tb_interconnect_four_data_to_sfft.sv
// Scoreboard bench for the four-quarter merge stage at NFFT=16.
module tb_interconnect_four_data_to_sfft;

  localparam int W = 16;

  logic clk;
  logic reset;
  logic cd [4];
  logic [W-1:0] di [4];
  logic [W-1:0] dq [4];
  logic rdy [4];
  logic flag_ready_fft;
  logic fft_valid;
  logic [W-1:0] data_to_fft_i;
  logic [W-1:0] data_to_fft_q;
  logic frame_start;
  logic busy;

  int total;
  int bad;
  int out_idx;
  int samples_seen;

  logic [31:0] sb0[$];
  logic [31:0] sb1[$];
  logic [31:0] sb2[$];
  logic [31:0] sb3[$];

  interconnect_four_data_to_sfft #(
    .SIZE_BUFFER  (4),
    .DATA_FFT_SIZE(W)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .complete_data0         (cd[0]),
    .complete_data1         (cd[1]),
    .complete_data2         (cd[2]),
    .complete_data3         (cd[3]),
    .data_in0_i             (di[0]),
    .data_in1_i             (di[1]),
    .data_in2_i             (di[2]),
    .data_in3_i             (di[3]),
    .data_in0_q             (dq[0]),
    .data_in1_q             (dq[1]),
    .data_in2_q             (dq[2]),
    .data_in3_q             (dq[3]),
    .flag_ready_recive_data0(rdy[0]),
    .flag_ready_recive_data1(rdy[1]),
    .flag_ready_recive_data2(rdy[2]),
    .flag_ready_recive_data3(rdy[3]),
    .flag_ready_fft         (flag_ready_fft),
    .fft_valid              (fft_valid),
    .data_to_fft_i          (data_to_fft_i),
    .data_to_fft_q          (data_to_fft_q),
    .frame_start            (frame_start),
    .busy                   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sb_size(input int k);
    case (k)
      0: return sb0.size();
      1: return sb1.size();
      2: return sb2.size();
      3: return sb3.size();
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] sb_front(input int k);
    case (k)
      0: return sb0[0];
      1: return sb1[0];
      2: return sb2[0];
      3: return sb3[0];
      default: return 32'h0;
    endcase
  endfunction

  function automatic void sb_pop(input int k);
    case (k)
      0: void'(sb0.pop_front());
      1: void'(sb1.pop_front());
      2: void'(sb2.pop_front());
      3: void'(sb3.pop_front());
      default: ;
    endcase
  endfunction

  function automatic void sb_push(input int k, input logic [31:0] v);
    case (k)
      0: sb0.push_back(v);
      1: sb1.push_back(v);
      2: sb2.push_back(v);
      3: sb3.push_back(v);
      default: ;
    endcase
  endfunction

  // Output order is quarter-major, so the bench's own sample index selects which queue to pop.
  always @(negedge clk) begin
    if (fft_valid === 1'b1) begin
      automatic int mq = out_idx / 4;
      total++;
      if (sb_size(mq) == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_valid: got sample i=%0d with nothing expected for quarter %0d", data_to_fft_i, mq);
      end else begin
        automatic logic [31:0] e = sb_front(mq);
        if ({data_to_fft_i, data_to_fft_q} !== e) begin
          bad++;
          $display("[TB] FAIL out_data idx=%0d: got i=%h q=%h, want i=%h q=%h", out_idx, data_to_fft_i, data_to_fft_q, e[31:16], e[15:0]);
        end
        total++;
        if (frame_start !== (out_idx == 0)) begin
          bad++;
          $display("[TB] FAIL frame_start idx=%0d: got %b, want %b", out_idx, frame_start, (out_idx == 0));
        end
        if (flag_ready_fft === 1'b1) begin
          sb_pop(mq);
          out_idx = (out_idx + 1) % 16;
          samples_seen++;
        end
      end
    end
  end

  task automatic fill_quarter(input int k, input int base, input int gap);
    for (int j = 0; j < 4; j++) begin
      automatic int budget = 0;
      cd[k] = 1'b0;
      repeat (gap) begin
        @(posedge clk); #1;
      end
      while (rdy[k] !== 1'b1 && budget < 300) begin
        @(posedge clk); #1;
        budget++;
      end
      if (rdy[k] !== 1'b1) begin
        total++;
        bad++;
        $display("[TB] FAIL ready_timeout quarter %0d: got %b, want 1", k, rdy[k]);
      end
      cd[k] = 1'b1;
      di[k] = W'(base + j);
      dq[k] = ~W'(base + j);
      sb_push(k, {W'(base + j), ~W'(base + j)});
      @(posedge clk); #1;
    end
    cd[k] = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int budget;
    budget = 0;
    while (samples_seen < target && budget < 600) begin
      @(posedge clk); #1;
      budget++;
    end
    total++;
    if (samples_seen !== target) begin
      bad++;
      $display("[TB] FAIL frame_count: got %0d samples, want %0d", samples_seen, target);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    flag_ready_fft = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cd[k] = 1'b0;
      di[k] = '0;
      dq[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({fft_valid, frame_start, busy, data_to_fft_i, data_to_fft_q} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got valid=%b fs=%b busy=%b i=%h q=%h, want all 0", fft_valid, frame_start, busy, data_to_fft_i, data_to_fft_q);
    end
    total++;
    if ({rdy[0], rdy[1], rdy[2], rdy[3]} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL reset_ready: got %b%b%b%b, want 0000", rdy[0], rdy[1], rdy[2], rdy[3]);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({rdy[0], rdy[1], rdy[2], rdy[3]} !== 4'b1111) begin
      bad++;
      $display("[TB] FAIL release_ready: got %b%b%b%b, want 1111", rdy[0], rdy[1], rdy[2], rdy[3]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int target;
    target = samples_seen + 16;
    for (int k = 0; k < 4; k++) fill_quarter(k, 4 * k, 0);
    total++;
    if (fft_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL latency_early: got fft_valid=%b, want 0", fft_valid);
    end
    @(posedge clk); #1;
    total++;
    if ({fft_valid, frame_start, busy, data_to_fft_i} !== {3'b111, 16'd0}) begin
      bad++;
      $display("[TB] FAIL first_valid: got valid=%b fs=%b busy=%b i=%0d, want 1 1 1 0", fft_valid, frame_start, busy, data_to_fft_i);
    end
    wait_frames(target);
  endtask

  task automatic test_gap_last;
    int target;
    target = samples_seen + 16;
    fill_quarter(0, 0, 0);
    fill_quarter(1, 4, 0);
    fill_quarter(3, 12, 0);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (fft_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL early_valid_q2_empty: got %b, want 0", fft_valid);
    end
    fill_quarter(2, 8, 1);
    total++;
    if (fft_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL early_valid_q2_just_full: got %b, want 0", fft_valid);
    end
    wait_frames(target);
  endtask

  task automatic test_full_ignore;
    int target;
    target = samples_seen + 16;
    fill_quarter(0, 0, 0);
    fill_quarter(1, 4, 0);
    for (int n = 0; n < 3; n++) begin
      total++;
      if (rdy[1] !== 1'b0) begin
        bad++;
        $display("[TB] FAIL ready1_while_full: got %b, want 0", rdy[1]);
      end
      cd[1] = 1'b1;
      di[1] = 16'hDEAD;
      dq[1] = 16'hBEEF;
      @(posedge clk); #1;
    end
    cd[1] = 1'b0;
    fill_quarter(2, 8, 0);
    fill_quarter(3, 12, 0);
    wait_frames(target);
  endtask

  task automatic test_stall;
    int target;
    int budget;
    bit pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    target = samples_seen + 16;
    flag_ready_fft = 1'b0;
    for (int k = 0; k < 4; k++) fill_quarter(k, 40 + 4 * k, 0);
    budget = 0;
    while (samples_seen < target && budget < 300) begin
      flag_ready_fft = pat[budget % 4];
      @(posedge clk); #1;
      budget++;
    end
    flag_ready_fft = 1'b1;
    wait_frames(target);
  endtask

  task automatic test_overlap;
    int target;
    target = samples_seen + 32;
    for (int k = 0; k < 4; k++) fill_quarter(k, 60 + 4 * k, 0);
    for (int k = 0; k < 4; k++) fill_quarter(k, 100 + 4 * k, 0);
    wait_frames(target);
  endtask

  task automatic test_mid_frame_reset;
    int target;
    int budget;
    target = samples_seen + 6;
    for (int k = 0; k < 4; k++) fill_quarter(k, 200 + 4 * k, 0);
    budget = 0;
    while (samples_seen < target && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    total++;
    if (data_to_fft_i !== 16'd206) begin
      bad++;
      $display("[TB] FAIL pre_reset_sample: got %0d, want 206", data_to_fft_i);
    end
    reset = 1'b0;
    sb0.delete();
    sb1.delete();
    sb2.delete();
    sb3.delete();
    out_idx = 0;
    #1;
    total++;
    if ({fft_valid, busy, data_to_fft_i, data_to_fft_q} !== '0) begin
      bad++;
      $display("[TB] FAIL abort_outputs: got valid=%b busy=%b i=%h q=%h, want all 0", fft_valid, busy, data_to_fft_i, data_to_fft_q);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    total++;
    if ({rdy[0], rdy[1], rdy[2], rdy[3]} !== 4'b1111) begin
      bad++;
      $display("[TB] FAIL ready_after_abort: got %b%b%b%b, want 1111", rdy[0], rdy[1], rdy[2], rdy[3]);
    end
    target = samples_seen + 16;
    for (int k = 0; k < 4; k++) fill_quarter(k, 300 + 4 * k, 0);
    wait_frames(target);
  endtask

  initial begin
    total = 0;
    bad = 0;
    out_idx = 0;
    samples_seen = 0;
    test_reset();
    test_back_to_back();
    test_gap_last();
    test_full_ignore();
    test_stall();
    test_overlap();
    test_mid_frame_reset();
    total++;
    if ((sb0.size() + sb1.size() + sb2.size() + sb3.size()) != 0) begin
      bad++;
      $display("[TB] FAIL leftover_expected: got %0d pending, want 0", sb0.size() + sb1.size() + sb2.size() + sb3.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
